// File: rtl/clock_pkg.sv
// Shared clock-display definitions: scan FSM states, digit indices and
// edit-pair codes (the pair codes are also used by the control unit).
package clock_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_t;

  localparam logic [1:0] DIG_MIN_ONES  = 2'd0;
  localparam logic [1:0] DIG_MIN_TENS  = 2'd1;
  localparam logic [1:0] DIG_HOUR_ONES = 2'd2;
  localparam logic [1:0] DIG_HOUR_TENS = 2'd3;

  localparam logic [1:0] EDIT_NONE = 2'b00;
  localparam logic [1:0] EDIT_MIN  = 2'b01;
  localparam logic [1:0] EDIT_HOUR = 2'b10;
  localparam logic [1:0] EDIT_ALL  = 2'b11;

  // True when digit idx belongs to the pair selected for editing.
  function automatic logic pair_member(input logic [1:0] idx, input logic [1:0] edit);
    case (edit)
      EDIT_MIN:  pair_member = (idx == DIG_MIN_ONES) || (idx == DIG_MIN_TENS);
      EDIT_HOUR: pair_member = (idx == DIG_HOUR_ONES) || (idx == DIG_HOUR_TENS);
      EDIT_ALL:  pair_member = 1'b1;
      default:   pair_member = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/display_scan_controller_blink_gen.sv
// Blink phase generator: counts scan frames, toggles the phase every
// BLINK_FRAMES frames and restarts visible whenever the edit pair changes.
module blink_gen #(
  parameter int BLINK_FRAMES = 50
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic [1:0] i_Edit,
  input  logic       i_Frame_Wrap,
  output logic       o_Phase_Next
);
  import clock_pkg::*;

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] frame_cnt_reg;
  logic [BW-1:0] frame_cnt_next;
  logic          phase_reg;
  logic [1:0]    edit_prev_reg;
  logic          edit_changed;

  assign edit_changed = (i_Edit != edit_prev_reg);

  // The phase look-ahead lets the top decide suppression on the same edge
  // that starts a new frame.
  always_comb begin
    frame_cnt_next = frame_cnt_reg;
    o_Phase_Next   = phase_reg;
    if (edit_changed) begin
      frame_cnt_next = '0;
      o_Phase_Next   = 1'b0;
    end else if (i_Frame_Wrap) begin
      if (frame_cnt_reg == BW'(BLINK_FRAMES - 1)) begin
        frame_cnt_next = '0;
        o_Phase_Next   = ~phase_reg;
      end else begin
        frame_cnt_next = frame_cnt_reg + BW'(1);
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      frame_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      edit_prev_reg <= EDIT_NONE;
    end else begin
      frame_cnt_reg <= frame_cnt_next;
      phase_reg     <= o_Phase_Next;
      edit_prev_reg <= i_Edit;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scan controller with blank gaps, edit blinking and
// seconds dot. Define LEADING_ZERO_BLANK_EN to hide a zero hours-tens digit.
module display_scan_controller #(
  parameter int SCAN_DIV     = 25000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic [3:0] i_Hours_Tens,
  input  logic [3:0] i_Hours_Ones,
  input  logic [3:0] i_Minutes_Tens,
  input  logic [3:0] i_Minutes_Ones,
  input  logic [1:0] i_Display_Enable_Digits,
  input  logic       i_Display_Enable_Dot,
  input  logic       i_Seconds_Tick,
  output logic [3:0] o_Digit_Select,
  output logic [3:0] o_BCD,
  output logic       o_Dot,
  output logic       o_Blank
);
  import clock_pkg::*;

  localparam int DRIVE_CYCLES = SCAN_DIV - BLANK_CYCLES;
  localparam int CW           = $clog2(SCAN_DIV + 1);

  scan_state_t   state_reg;
  logic [CW-1:0] slot_cnt_reg;
  logic [1:0]    idx_reg;
  logic          supp_reg;
  logic          dot_phase_reg;

  logic       blank_done;
  logic       drive_done;
  logic       frame_wrap;
  logic [1:0] idx_next;
  logic [1:0] idx_now;
  logic [3:0] bcd_sel;
  logic       blink_phase_next;
  logic       lead_zero;
  logic       supp_next;
  logic       supp_now;
  logic       drive_next;
  logic       dot_phase_next;

  assign blank_done = (state_reg == S_BLANK) && (slot_cnt_reg == CW'(BLANK_CYCLES - 1));
  assign drive_done = (state_reg == S_DRIVE) && (slot_cnt_reg == CW'(DRIVE_CYCLES - 1));
  assign idx_next   = idx_reg + 2'd1;
  assign frame_wrap = blank_done && (idx_next == DIG_MIN_ONES);

  always_comb begin
    case (idx_next)
      DIG_MIN_ONES:  bcd_sel = i_Minutes_Ones;
      DIG_MIN_TENS:  bcd_sel = i_Minutes_Tens;
      DIG_HOUR_ONES: bcd_sel = i_Hours_Ones;
      default:       bcd_sel = i_Hours_Tens;
    endcase
  end

  blink_gen #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_gen (
    .i_Clock      (i_Clock),
    .i_Reset_n    (i_Reset_n),
    .i_Edit       (i_Display_Enable_Digits),
    .i_Frame_Wrap (frame_wrap),
    .o_Phase_Next (blink_phase_next)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign lead_zero = (idx_next == DIG_HOUR_TENS) && (bcd_sel == 4'd0);
`else
  assign lead_zero = 1'b0;
`endif

  // Suppression is decided once at slot entry and held for the slot.
  assign supp_next      = (blink_phase_next && pair_member(idx_next, i_Display_Enable_Digits)) || lead_zero;
  assign supp_now       = blank_done ? supp_next : supp_reg;
  assign idx_now        = blank_done ? idx_next : idx_reg;
  assign drive_next     = blank_done || ((state_reg == S_DRIVE) && !drive_done);
  assign dot_phase_next = i_Display_Enable_Dot ? (dot_phase_reg ^ i_Seconds_Tick) : 1'b0;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_reg      <= S_BLANK;
      slot_cnt_reg   <= '0;
      idx_reg        <= DIG_HOUR_TENS;
      supp_reg       <= 1'b0;
      dot_phase_reg  <= 1'b0;
      o_Digit_Select <= 4'b1111;
      o_BCD          <= 4'd0;
      o_Dot          <= 1'b0;
      o_Blank        <= 1'b1;
    end else begin
      dot_phase_reg <= dot_phase_next;
      // The dot follows its enable and phase every cycle, not only at slot entry.
      o_Dot <= drive_next && (idx_now == DIG_HOUR_ONES) && i_Display_Enable_Dot &&
               dot_phase_next && !supp_now;
      case (state_reg)
        S_BLANK: begin
          if (blank_done) begin
            state_reg      <= S_DRIVE;
            slot_cnt_reg   <= '0;
            idx_reg        <= idx_next;
            o_BCD          <= bcd_sel;
            supp_reg       <= supp_next;
            o_Digit_Select <= supp_next ? 4'b1111 : ~(4'b0001 << idx_next);
            o_Blank        <= supp_next;
          end else begin
            slot_cnt_reg <= slot_cnt_reg + CW'(1);
          end
        end
        S_DRIVE: begin
          if (drive_done) begin
            state_reg      <= S_BLANK;
            slot_cnt_reg   <= '0;
            o_Digit_Select <= 4'b1111;
            o_Blank        <= 1'b1;
          end else begin
            slot_cnt_reg <= slot_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg    <= S_BLANK;
          slot_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: per-cycle reference model
// feeding a scoreboard, a vector table and directed corner-case sequences.
module tb_display_scan_controller;

  localparam int SD  = 8;
  localparam int BC  = 2;
  localparam int BF  = 2;
  localparam int DRV = SD - BC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] ht, ho, mt, mo;
  logic [1:0] edit;
  logic       dot_en, tick;
  logic [3:0] ds, bcd_o;
  logic       dot_o, blank_o;

  always #5 clk = ~clk;

  display_scan_controller #(
    .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)
  ) dut (
    .i_Clock(clk), .i_Reset_n(rst_n),
    .i_Hours_Tens(ht), .i_Hours_Ones(ho), .i_Minutes_Tens(mt), .i_Minutes_Ones(mo),
    .i_Display_Enable_Digits(edit), .i_Display_Enable_Dot(dot_en), .i_Seconds_Tick(tick),
    .o_Digit_Select(ds), .o_BCD(bcd_o), .o_Dot(dot_o), .o_Blank(blank_o)
  );

  typedef struct packed {
    logic [3:0] ds;
    logic [3:0] bcd;
    logic       dot;
    logic       blank;
  } exp_t;

  typedef struct {
    logic [3:0] ht, ho, mt, mo;
    logic [1:0] edit;
    logic       dot_en;
    int         tick_at;
    int         cycles;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference model state (time since reset release, blink, dot, latch).
  int         m_k, m_cnt, m_idx, m_r;
  logic       m_drive, m_ph, m_supp, m_dotph;
  logic [1:0] m_prev;
  logic [3:0] m_bcd;

  task automatic model_reset();
    m_k = 0; m_cnt = 0; m_idx = 3; m_r = -1; m_drive = 1'b0;
    m_ph = 1'b0; m_supp = 1'b0; m_dotph = 1'b0; m_prev = 2'b00; m_bcd = 4'd0;
    sb_q.delete();
  endtask

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got ds=%b bcd=%0d dot=%b blank=%b, expected ds=%b bcd=%0d dot=%b blank=%b",
               name, $time, act.ds, act.bcd, act.dot, act.blank, exp.ds, exp.bcd, exp.dot, exp.blank);
    end
  endtask

  function automatic logic in_pair(input int idx, input logic [1:0] e);
    if (e == 2'b11) return 1'b1;
    if (e == 2'b01) return (idx < 2);
    if (e == 2'b10) return (idx >= 2);
    return 1'b0;
  endfunction

  function automatic logic [3:0] digit_val(input int idx);
    case (idx)
      0: return mo;
      1: return mt;
      2: return ho;
      default: return ht;
    endcase
  endfunction

  // Predict the outputs after the coming edge, queue them, clock, compare.
  task automatic step();
    int q, s;
    logic wrap;
    logic [3:0] an;
    exp_t e, got;
    m_k++;
    q = m_k - BC;
    wrap = 1'b0;
    m_drive = 1'b0;
    m_r = -1;
    if (q >= 0) begin
      s = q / SD;
      m_r = q % SD;
      m_idx = s % 4;
      m_drive = (m_r < DRV);
      wrap = (m_r == 0) && (m_idx == 0);
    end
    if (edit != m_prev) begin
      m_cnt = 0; m_ph = 1'b0;
    end else if (wrap) begin
      if (m_cnt + 1 == BF) begin m_cnt = 0; m_ph = ~m_ph; end
      else m_cnt++;
    end
    m_prev = edit;
    if (m_r == 0) begin
      m_bcd = digit_val(m_idx);
      m_supp = m_ph && in_pair(m_idx, edit);
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx == 3 && m_bcd == 4'd0) m_supp = 1'b1;
`endif
    end
    m_dotph = dot_en ? (m_dotph ^ tick) : 1'b0;
    an = 4'b1111;
    if (m_drive && !m_supp) an[m_idx] = 1'b0;
    e.ds    = an;
    e.bcd   = m_bcd;
    e.blank = !m_drive || m_supp;
    e.dot   = m_drive && (m_idx == 2) && dot_en && m_dotph && !m_supp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = '{ds: ds, bcd: bcd_o, dot: dot_o, blank: blank_o};
    e = sb_q.pop_front();
    check("cycle", got, e);
  endtask

  task automatic check_reset_outputs(input string name);
    exp_t got;
    got = '{ds: ds, bcd: bcd_o, dot: dot_o, blank: blank_o};
    check(name, got, '{ds: 4'b1111, bcd: 4'd0, dot: 1'b0, blank: 1'b1});
  endtask

  initial begin
    int guard;
    exp_t got;
    vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd5, 2'b00, 1'b0, -1, 64};
    vecs[1] = '{4'd1, 4'd2, 4'd3, 4'd5, 2'b01, 1'b0, -1, 200};
    vecs[2] = '{4'd1, 4'd2, 4'd3, 4'd5, 2'b10, 1'b0, -1, 100};
    vecs[3] = '{4'd1, 4'd2, 4'd3, 4'd5, 2'b00, 1'b1,  0, 64};
    vecs[4] = '{4'd1, 4'd2, 4'd3, 4'd5, 2'b00, 1'b1,  0, 40};
    vecs[5] = '{4'd1, 4'd2, 4'd3, 4'd5, 2'b00, 1'b1,  0, 40};
    vecs[6] = '{4'd1, 4'd2, 4'd3, 4'd5, 2'b00, 1'b0,  0, 40};
    vecs[7] = '{4'd1, 4'd2, 4'd3, 4'd5, 2'b00, 1'b1, -1, 40};
    vecs[8] = '{4'd1, 4'd2, 4'd3, 4'd5, 2'b11, 1'b1,  5, 200};
    vecs[9] = '{4'd0, 4'd2, 4'd3, 4'd5, 2'b00, 1'b0, -1, 64};

    ht = 4'd1; ho = 4'd2; mt = 4'd3; mo = 4'd5;
    edit = 2'b00; dot_en = 1'b0; tick = 1'b0;

    // Asynchronous reset: outputs settle before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset_held");
    model_reset();
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      ht = vecs[v].ht; ho = vecs[v].ho; mt = vecs[v].mt; mo = vecs[v].mo;
      edit = vecs[v].edit; dot_en = vecs[v].dot_en;
      $display("vec %0d: time %0d%0d:%0d%0d edit=%b dot_en=%b tick_at=%0d cycles=%0d",
               v, ht, ho, mt, mo, edit, dot_en, vecs[v].tick_at, vecs[v].cycles);
      for (int c = 0; c < vecs[v].cycles; c++) begin
        tick = (c == vecs[v].tick_at);
        step();
      end
      tick = 1'b0;
    end

    // Mid-slot input change: the latched digit-0 value must hold.
    ht = 4'd1; mo = 4'd5; edit = 2'b00; dot_en = 1'b0;
    guard = 0;
    while (!(m_drive && m_idx == 0 && m_r == 2) && guard < 100) begin step(); guard++; end
    if (guard >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL find_digit0_slot: no digit-0 drive slot within 100 cycles");
    end
    mo = 4'd6;
    step();
    n_cmp++;
    if (bcd_o !== 4'd5) begin
      n_fail++;
      $display("FAIL bcd_hold: got %0d, expected 5", bcd_o);
    end
    $display("seq bcd_hold: minutes ones 5->6 mid-slot, o_BCD=%0d", bcd_o);
    guard = 0;
    do begin step(); guard++; end while (!(m_drive && m_idx == 0 && m_r == 0) && guard < 100);
    n_cmp++;
    if (bcd_o !== 4'd6 || guard >= 100) begin
      n_fail++;
      $display("FAIL bcd_update: got %0d, expected 6 at next digit-0 slot", bcd_o);
    end

    // Reset asserted between edges in the middle of a drive slot.
    guard = 0;
    while (!(m_drive && m_r == 3) && guard < 100) begin step(); guard++; end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_drive");
    $display("seq reset_mid_drive: anodes=%b blank=%b", ds, blank_o);
    @(posedge clk); #1;
    check_reset_outputs("reset_mid_drive_held");
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) step();

    got = '{ds: ds, bcd: bcd_o, dot: dot_o, blank: blank_o};
    if (sb_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("final outputs ds=%b bcd=%0d dot=%b blank=%b", got.ds, got.bcd, got.dot, got.blank);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
